// File: rtl/core_link_master_if.sv
// ---------------------------------------------------------------------------
// core_link_master_if
//   Groups the host-side streams and the core-side word link of
//   core_link_master into one bundle.
//
//   Parameter
//     RX_DEPTH     receive FIFO depth; sets the width of rx_level
//
//   Signals (directions as seen by the master, i.e. core_link_master)
//     tx_word      in   16  upstream word to send
//     tx_valid     in    1  upstream word available
//     tx_ready     out   1  word accepted this cycle
//     rx_word      out  16  head of receive FIFO
//     rx_valid     out   1  receive FIFO not empty
//     rx_ready     in    1  upstream pops on rx_valid & rx_ready
//     link_data    out  16  to core data_in
//     link_valid   out   1  to core data_in_valid
//     link_rdata   in   16  from core data_out
//     link_rvalid  in    1  from core data_out_valid
//     link_done    out   1  to core tx_done
//     rx_overflow  out   1  sticky protocol-violation flag
//     rx_level     out   L  receive FIFO occupancy, L = clog2(RX_DEPTH)+1
//
//   Modports
//     master  core_link_master side
//     slave   host driver / core model side
// ---------------------------------------------------------------------------
interface core_link_master_if #(
  parameter int RX_DEPTH = 4
);
  localparam int LVL_W = $clog2(RX_DEPTH) + 1;

  logic [15:0]      tx_word;
  logic             tx_valid;
  logic             tx_ready;
  logic [15:0]      rx_word;
  logic             rx_valid;
  logic             rx_ready;
  logic [15:0]      link_data;
  logic             link_valid;
  logic [15:0]      link_rdata;
  logic             link_rvalid;
  logic             link_done;
  logic             rx_overflow;
  logic [LVL_W-1:0] rx_level;

  modport master (
    input  tx_word, tx_valid, rx_ready, link_rdata, link_rvalid,
    output tx_ready, rx_word, rx_valid, link_data, link_valid,
           link_done, rx_overflow, rx_level
  );

  modport slave (
    output tx_word, tx_valid, rx_ready, link_rdata, link_rvalid,
    input  tx_ready, rx_word, rx_valid, link_data, link_valid,
           link_done, rx_overflow, rx_level
  );
endinterface

// File: rtl/core_link_master.sv
// ---------------------------------------------------------------------------
// core_link_master
//   Host-side partner of the processing core's word link.
//
//   Send path: accepts 16-bit words from an upstream valid/ready stream and
//   presents each one to the core as one clean pulse of link_valid
//   (HOLD_CYCLES high, GAP_CYCLES low), with link_data stable from accept
//   until the next accept.
//
//   Receive path: captures each word on a rising edge of link_rvalid, stores
//   it in a small first-word-fall-through FIFO and answers with a link_done
//   pulse of DONE_CYCLES cycles. When the FIFO is full the word waits in a
//   skid register and link_done is withheld, which stalls the core.
//
//   Ports
//     clk   clock, everything on posedge
//     rst   synchronous reset, active-high
//     bus   core_link_master_if.master (host streams + core link)
//
//   Parameters
//     HOLD_CYCLES  link_valid high time per word (>=1)
//     GAP_CYCLES   link_valid low time after each word (>=1)
//     DONE_CYCLES  link_done high time per captured word (>=1)
//     RX_DEPTH     receive FIFO depth, power of 2, >=2
// ---------------------------------------------------------------------------
module core_link_master #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int DONE_CYCLES = 2,
  parameter int RX_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  core_link_master_if.master    bus
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(RX_DEPTH);

  // -------------------------------------------------------------------------
  // Send FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } send_state_t;

  send_state_t      s_state_reg, s_state_next;
  logic [CNT_W-1:0] s_cnt_reg, s_cnt_next;
  logic [15:0]      link_data_reg, link_data_next;
  logic             link_valid_reg, link_valid_next;
  logic             tx_ready_reg, tx_ready_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_state_reg    <= S_IDLE;
      s_cnt_reg      <= '0;
      link_data_reg  <= '0;
      link_valid_reg <= 1'b0;
      tx_ready_reg   <= 1'b0;
    end else begin
      s_state_reg    <= s_state_next;
      s_cnt_reg      <= s_cnt_next;
      link_data_reg  <= link_data_next;
      link_valid_reg <= link_valid_next;
      tx_ready_reg   <= tx_ready_next;
    end
  end

  always_comb begin
    s_state_next   = s_state_reg;
    s_cnt_next     = s_cnt_reg;
    link_data_next = link_data_reg;

    unique case (s_state_reg)
      S_IDLE: begin
        // tx_ready_reg is low in the first idle cycle after reset, so the
        // accept test uses the registered ready rather than the state alone.
        if (bus.tx_valid && tx_ready_reg) begin
          link_data_next = bus.tx_word;
          s_cnt_next     = '0;
          s_state_next   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (s_cnt_reg == HOLD_LAST) begin
          s_cnt_next   = '0;
          s_state_next = S_GAP;
        end else begin
          s_cnt_next = s_cnt_reg + 1'b1;
        end
      end
      S_GAP: begin
        if (s_cnt_reg == GAP_LAST) begin
          s_cnt_next   = '0;
          s_state_next = S_IDLE;
        end else begin
          s_cnt_next = s_cnt_reg + 1'b1;
        end
      end
      default: begin
        s_cnt_next   = '0;
        s_state_next = S_IDLE;
      end
    endcase

    // Both outputs are registered copies of the next state, so they change
    // on the same edge as the state they describe.
    link_valid_next = (s_state_next == S_HOLD);
    tx_ready_next   = (s_state_next == S_IDLE);
  end

  // -------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // -------------------------------------------------------------------------
  logic [15:0]      mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;
  logic [15:0]      push_data;

  assign fifo_full = (level_reg == LVL_FULL);
  assign fifo_pop  = (level_reg != '0) && bus.rx_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    // Pointers are PTR_W bits wide, so the increment wraps modulo RX_DEPTH.
    if (fifo_push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (fifo_push && !fifo_pop) begin
      level_next = level_reg + 1'b1;
    end else if (!fifo_push && fifo_pop) begin
      level_next = level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Storage needs no reset: rx_valid masks every entry until it is written.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // -------------------------------------------------------------------------
  // Receive edge detect and FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_WAIT,
    R_STALL,
    R_DONE,
    R_GAP
  } recv_state_t;

  recv_state_t      r_state_reg, r_state_next;
  logic [CNT_W-1:0] r_cnt_reg, r_cnt_next;
  logic [15:0]      skid_reg, skid_next;
  logic             rvalid_prev_reg;
  logic             link_done_reg, link_done_next;
  logic             overflow_reg, overflow_next;
  logic             rise;

  // rvalid_prev_reg resets high so a link_rvalid level held across reset is
  // not mistaken for a new word.
  assign rise = bus.link_rvalid && !rvalid_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg     <= R_WAIT;
      r_cnt_reg       <= '0;
      skid_reg        <= '0;
      rvalid_prev_reg <= 1'b1;
      link_done_reg   <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      r_state_reg     <= r_state_next;
      r_cnt_reg       <= r_cnt_next;
      skid_reg        <= skid_next;
      rvalid_prev_reg <= bus.link_rvalid;
      link_done_reg   <= link_done_next;
      overflow_reg    <= overflow_next;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    r_cnt_next   = r_cnt_reg;
    skid_next    = skid_reg;
    fifo_push    = 1'b0;
    push_data    = bus.link_rdata;

    unique case (r_state_reg)
      R_WAIT: begin
        if (rise) begin
          if (!fifo_full) begin
            fifo_push    = 1'b1;
            r_cnt_next   = '0;
            r_state_next = R_DONE;
          end else begin
            skid_next    = bus.link_rdata;
            r_state_next = R_STALL;
          end
        end
      end
      R_STALL: begin
        // fifo_full is the registered level, so a pop lands as free space
        // one cycle later; the push therefore never meets a full FIFO.
        if (!fifo_full) begin
          fifo_push    = 1'b1;
          push_data    = skid_reg;
          r_cnt_next   = '0;
          r_state_next = R_DONE;
        end
      end
      R_DONE: begin
        if (r_cnt_reg == DONE_LAST) begin
          r_cnt_next   = '0;
          r_state_next = R_GAP;
        end else begin
          r_cnt_next = r_cnt_reg + 1'b1;
        end
      end
      R_GAP: begin
        // One low cycle of link_done so the core sees a fresh edge next time.
        r_state_next = R_WAIT;
      end
      default: begin
        r_cnt_next   = '0;
        r_state_next = R_WAIT;
      end
    endcase

    // A word arriving while the previous one is still being acknowledged is
    // dropped; the flag records that the core broke the handshake.
    overflow_next  = overflow_reg || (rise && (r_state_reg != R_WAIT));
    link_done_next = (r_state_next == R_DONE);
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.tx_ready    = tx_ready_reg;
  assign bus.link_data   = link_data_reg;
  assign bus.link_valid  = link_valid_reg;
  assign bus.link_done   = link_done_reg;
  assign bus.rx_overflow = overflow_reg;
  assign bus.rx_level    = level_reg;
  assign bus.rx_valid    = (level_reg != '0);
  assign bus.rx_word     = mem[rd_ptr_reg];

endmodule

// File: tb/tb_core_link_master.sv
// ---------------------------------------------------------------------------
// tb_core_link_master
//   Drives core_link_master from a host driver and a core model, and checks
//   timing and data against expectations derived from the link rules:
//   send pulse lengths, FIFO order/occupancy, done pulse, stall, overflow,
//   a 128-word echo stream and reset in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_core_link_master;
  localparam int HOLD  = 2;
  localparam int GAP   = 2;
  localparam int DONE  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  core_link_master_if #(.RX_DEPTH(DEPTH)) bus ();

  core_link_master #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .DONE_CYCLES (DONE),
    .RX_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];              // words the FIFO must hold, oldest first

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one word upstream; expects HOLD high cycles, GAP low cycles and
  // tx_ready back on the following cycle.
  task automatic send_word(input logic [15:0] w, input bit last);
    int guard = 0;
    while (bus.tx_ready !== 1'b1 && guard < 50) begin
      tick;
      guard++;
    end
    check("tx_ready_wait", bus.tx_ready, 1);
    bus.tx_word  = w;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < HOLD; i++) begin
      tick;
      if (last && i == 0) bus.tx_valid = 1'b0;
      check("hold_valid", bus.link_valid, 1);
      check("hold_data", bus.link_data, w);
      check("hold_ready", bus.tx_ready, 0);
    end
    for (int i = 0; i < GAP; i++) begin
      tick;
      check("gap_valid", bus.link_valid, 0);
      check("gap_data", bus.link_data, w);
      check("gap_ready", bus.tx_ready, 0);
    end
    tick;
    check("ready_back", bus.tx_ready, 1);
    $display("send word 0x%04h", w);
  endtask

  // Core model: one link_rvalid pulse carrying w.
  task automatic core_push(input logic [15:0] w);
    bus.link_rdata  = w;
    bus.link_rvalid = 1'b1;
    tick;
    bus.link_rvalid = 1'b0;
  endtask

  // Core model: wait for the done pulse to finish and the gap cycle to pass.
  task automatic wait_done_cycle;
    int guard = 0;
    while (bus.link_done !== 1'b1 && guard < 100) begin
      tick;
      guard++;
    end
    check("done_seen", bus.link_done, 1);
    guard = 0;
    while (bus.link_done !== 1'b0 && guard < 100) begin
      tick;
      guard++;
    end
    check("done_fall", bus.link_done, 0);
    tick;
  endtask

  // Pop everything the model expects, checking order.
  task automatic drain;
    int w;
    while (exp_q.size() > 0) begin
      check("drain_valid", bus.rx_valid, 1);
      check("drain_word", bus.rx_word, exp_q[0]);
      $display("pop word 0x%04h", bus.rx_word);
      w = exp_q.pop_front();
      bus.rx_ready = 1'b1;
      tick;
    end
    bus.rx_ready = 1'b0;
    check("drain_level", bus.rx_level, 0);
    check("drain_empty", bus.rx_valid, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    check("rst_link_valid", bus.link_valid, 0);
    check("rst_link_data", bus.link_data, 0);
    check("rst_link_done", bus.link_done, 0);
    check("rst_tx_ready", bus.tx_ready, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_level", bus.rx_level, 0);
    check("rst_overflow", bus.rx_overflow, 0);
    rst = 1'b0;
    tick;
    check("ready_after_rst", bus.tx_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] a;
    logic [15:0] b;
    int          tx_idx, core_rx_cnt, rx_cnt, phase, max_lvl, cyc;
    bit          acc;
    logic        lv_prev;
    int          core_out[$];

    bus.tx_word     = '0;
    bus.tx_valid    = 1'b0;
    bus.rx_ready    = 1'b0;
    bus.link_rdata  = '0;
    bus.link_rvalid = 1'b0;

    do_reset;

    // 1: two back-to-back words, tx_valid held
    send_word(16'h0003, 1'b0);
    send_word(16'h1234, 1'b1);
    check("idle_after_send", bus.link_valid, 0);

    // 2: single capture with rx_ready low
    core_push(16'hBEEF);
    exp_q.push_back(16'hBEEF);
    $display("core word 0xbeef");
    check("t2_level", bus.rx_level, 1);
    check("t2_word", bus.rx_word, 16'hBEEF);
    check("t2_valid", bus.rx_valid, 1);
    check("t2_done1", bus.link_done, 1);
    tick;
    check("t2_done2", bus.link_done, 1);
    tick;
    check("t2_done_gap", bus.link_done, 0);
    tick;
    check("t2_done_idle", bus.link_done, 0);
    check("t2_overflow", bus.rx_overflow, 0);

    // 3: fill FIFO, fifth word stalls until one pop
    for (int i = 0; i < DEPTH - 1; i++) begin
      w = 16'($urandom);
      core_push(w);
      exp_q.push_back(w);
      $display("core word 0x%04h", w);
      wait_done_cycle;
    end
    check("t3_full_level", bus.rx_level, DEPTH);
    core_push(16'h0055);
    $display("core word 0x0055 (stall expected)");
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_done", bus.link_done, 0);
      check("t3_stall_level", bus.rx_level, DEPTH);
      tick;
    end
    check("t3_pop_word", bus.rx_word, exp_q[0]);
    w = 16'(exp_q.pop_front());
    bus.rx_ready = 1'b1;
    tick;
    bus.rx_ready = 1'b0;
    check("t3_after_pop_level", bus.rx_level, DEPTH - 1);
    check("t3_after_pop_done", bus.link_done, 0);
    tick;
    exp_q.push_back(16'h0055);
    check("t3_skid_level", bus.rx_level, DEPTH);
    check("t3_skid_done", bus.link_done, 1);
    wait_done_cycle;
    check("t3_overflow", bus.rx_overflow, 0);
    drain;

    // 4: second rise while link_done high is dropped and flagged
    a = 16'($urandom);
    b = 16'($urandom);
    core_push(a);
    exp_q.push_back(a);
    $display("core word 0x%04h, then 0x%04h during done", a, b);
    check("t4_done_a", bus.link_done, 1);
    tick;
    check("t4_done_b", bus.link_done, 1);
    core_push(b);
    check("t4_overflow", bus.rx_overflow, 1);
    check("t4_level", bus.rx_level, 1);
    check("t4_word", bus.rx_word, a);
    for (int i = 0; i < 10; i++) tick;
    check("t4_overflow_sticky", bus.rx_overflow, 1);
    check("t4_level_kept", bus.rx_level, 1);
    drain;
    check("t4_overflow_after_drain", bus.rx_overflow, 1);

    do_reset;

    // 5: mode word + 128 samples, core echoes samples, random rx_ready
    tx_idx      = 0;
    core_rx_cnt = 0;
    rx_cnt      = 0;
    phase       = 0;
    max_lvl     = 0;
    cyc         = 0;
    acc         = 1'b0;
    lv_prev     = 1'b0;
    while (rx_cnt < 128 && cyc < 20000) begin
      if (acc) tx_idx++;
      bus.tx_valid = (tx_idx < 129);
      bus.tx_word  = (tx_idx == 0) ? 16'h0000 : 16'(tx_idx - 1);
      acc = bus.tx_valid && bus.tx_ready;

      if (bus.link_valid && !lv_prev) begin
        if (core_rx_cnt == 0) begin
          check("s_mode_word", bus.link_data, 0);
        end else begin
          check("s_core_rx", bus.link_data, core_rx_cnt - 1);
          core_out.push_back(int'(bus.link_data));
        end
        core_rx_cnt++;
      end
      lv_prev = bus.link_valid;

      if (phase == 3) phase = 0;
      if (phase == 1) begin
        bus.link_rvalid = 1'b0;
        if (bus.link_done) phase = 2;
      end else if (phase == 2) begin
        if (!bus.link_done) phase = 3;
      end else if (phase == 0 && core_out.size() > 0) begin
        bus.link_rdata  = 16'(core_out.pop_front());
        bus.link_rvalid = 1'b1;
        phase = 1;
      end

      bus.rx_ready = 1'($urandom_range(0, 1));
      if (bus.rx_valid && bus.rx_ready) begin
        check("s_rx_word", bus.rx_word, rx_cnt);
        $display("stream pop %0d word 0x%04h", rx_cnt, bus.rx_word);
        rx_cnt++;
      end
      if (int'(bus.rx_level) > max_lvl) max_lvl = int'(bus.rx_level);
      tick;
      cyc++;
    end
    bus.rx_ready    = 1'b0;
    bus.tx_valid    = 1'b0;
    bus.link_rvalid = 1'b0;
    check("s_rx_count", rx_cnt, 128);
    check("s_core_count", core_rx_cnt, 129);
    check("s_level_bound", (max_lvl <= DEPTH), 1);
    check("s_overflow", bus.rx_overflow, 0);
    tick;
    tick;

    // 6: reset in the middle of S_HOLD with link_rvalid held high
    bus.tx_word  = 16'hA5A5;
    bus.tx_valid = 1'b1;
    cyc = 0;
    while (bus.tx_ready !== 1'b1 && cyc < 50) begin
      tick;
      cyc++;
    end
    tick;
    bus.tx_valid = 1'b0;
    check("r_in_hold", bus.link_valid, 1);
    bus.link_rdata  = 16'h1111;
    bus.link_rvalid = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("r_link_valid", bus.link_valid, 0);
    check("r_link_done", bus.link_done, 0);
    check("r_level", bus.rx_level, 0);
    check("r_tx_ready", bus.tx_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("r_no_capture", bus.rx_level, 0);
      check("r_no_done", bus.link_done, 0);
      check("r_no_valid", bus.link_valid, 0);
    end
    check("r_ready_back", bus.tx_ready, 1);
    bus.link_rvalid = 1'b0;
    tick;
    core_push(16'h2222);
    $display("core word 0x2222 after reset");
    check("r_capture_level", bus.rx_level, 1);
    check("r_capture_word", bus.rx_word, 16'h2222);
    check("r_capture_done", bus.link_done, 1);
    check("r_overflow", bus.rx_overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/core_link_master.md
Name: core_link_master

Overview:
- Host-side partner of the processing core's word link.
- Send path: takes 16-bit words from an upstream valid/ready stream and drives them onto the core's receive channel. Each word is marked by one clean rising edge of link_valid.
- Receive path: captures each word the core transmits (rising edge of link_rvalid), buffers it in a small FIFO, and returns a link_done pulse so the core advances.
- Sits between the host interface logic (SPI/UART bridge, testbench driver) and the core.

Parameters:
HOLD_CYCLES, 2, clk cycles link_valid stays high per word (>=1)
GAP_CYCLES, 2, clk cycles link_valid stays low after each word (>=1)
DONE_CYCLES, 2, clk cycles link_done stays high per acknowledged word (>=1)
RX_DEPTH, 4, receive FIFO depth in words (power of 2, >=2)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
tx_word  input  16  upstream word to send (mode word or sample)
tx_valid  input  1  upstream word available
tx_ready  output  1  block accepts tx_word this cycle
rx_word  output  16  head of receive FIFO
rx_valid  output  1  receive FIFO not empty
rx_ready  input  1  upstream pops rx_word when rx_valid & rx_ready
link_data  output  16  to core data_in
link_valid  output  1  to core data_in_valid
link_rdata  input  16  from core data_out
link_rvalid  input  1  from core data_out_valid
link_done  output  1  to core tx_done
rx_overflow  output  1  sticky protocol-violation flag
rx_level  output  $clog2(RX_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: clk is the only clock; rst is synchronous, active-high.
  - Reset outputs: link_data=0, link_valid=0, link_done=0, tx_ready=0, rx_valid=0, rx_level=0, rx_overflow=0.
  - Reset clears the FIFO and returns both FSMs to their idle states.
  - rvalid_prev resets to 1, so a link_rvalid level held high across reset is not an edge.
  - Reset mid-operation aborts any word in flight without completing its handshake.
- Send FSM, states S_IDLE, S_HOLD, S_GAP:
  - S_IDLE: tx_ready=1 (registered; high the cycle after reset deasserts).
    - On tx_valid & tx_ready: link_data <= tx_word, link_valid <= 1, counter <= 0, go to S_HOLD.
  - S_HOLD: count HOLD_CYCLES cycles with link_valid=1, then link_valid <= 0, go to S_GAP.
  - S_GAP: count GAP_CYCLES cycles with link_valid=0, then go to S_IDLE.
  - tx_ready=0 in S_HOLD and S_GAP.
  - link_data stays stable from accept until the next accept; it is never changed while link_valid=1.
  - Per-word period is HOLD_CYCLES+GAP_CYCLES+1 cycles; back-to-back words produce one distinct rising edge each.
  - The send path ignores core state and the receive path; the host sequences commands.
- Receive edge detect: rvalid_prev <= link_rvalid every cycle; rise = link_rvalid & ~rvalid_prev.
  - link_rvalid/link_rdata are sampled directly; they are synchronous to clk and no synchronizer is used.
- Receive FSM, states R_WAIT, R_STALL, R_DONE, R_GAP:
  - R_WAIT, on rise:
    - FIFO not full: push link_rdata, go to R_DONE.
    - FIFO full: latch link_rdata into a skid register, go to R_STALL.
  - R_STALL: push the skid word on the first cycle the FIFO is not full (a pop in the same cycle counts as space next cycle), then go to R_DONE. link_done stays 0 while stalled, which backpressures the core.
  - R_DONE: link_done=1 for DONE_CYCLES cycles, then go to R_GAP.
  - R_GAP: link_done=0 for 1 cycle, then go to R_WAIT. This guarantees a fresh rising edge next time.
  - link_done rises no earlier than the cycle after the word is pushed.
- Protocol violation: a rise seen in R_STALL, R_DONE or R_GAP drops that word and sets rx_overflow=1. rx_overflow stays set until rst.
- FIFO:
  - First-word-fall-through; rx_word is valid whenever rx_valid=1.
  - Pop on rx_valid & rx_ready. Simultaneous push and pop leaves rx_level unchanged.
  - Pointers wrap modulo RX_DEPTH. Pop when empty and push when full are impossible by construction.
  - rx_level counts 0..RX_DEPTH.

Test Plan:
1. HOLD=2, GAP=2; send 0x0003 then 0x1234 back-to-back, tx_valid held -> link_valid high 2 cycles / low 2 cycles per word; link_data 0x0003 then 0x1234; tx_ready pulses once per 5 cycles.
2. Core pulses link_rvalid with link_rdata=0xBEEF, rx_ready=0 -> rx_level=1, rx_word=0xBEEF; link_done high exactly 2 cycles starting 1 cycle after push; rx_overflow=0.
3. Fill FIFO with 4 words (rx_ready=0), core sends a 5th word 0x0055 -> R_STALL, link_done stays 0; raise rx_ready for one pop -> 0x0055 pushed, link_done pulses, order of rx_word preserved, rx_level returns to 4.
4. Second link_rvalid rise while link_done high -> word dropped, rx_overflow=1 and stays 1 until rst; FIFO contents unchanged.
5. Stream 128 words (0..127) in and out: driver sends mode 0x0000 plus 128 samples; core model echoes 128 words -> all 128 received in order, no overflow, rx_level never exceeds 4.
6. Assert rst mid-S_HOLD with link_rvalid held high -> next cycle link_valid=0, link_done=0, rx_level=0; after release no capture until link_rvalid falls and rises again.
